div_sched: RTL and testbench
============================

# div_sched

Sequencer and two-port arbiter for the shared restoring divider core. Accepts divide requests from two requesters over valid/ready handshakes, grants round-robin, loads and steps the core for exactly WIDTH iterations, and returns the quotient with a divide-by-zero flag and requester ID on a held response channel. It sits between the datapath clients and the single `div_core` instance, and is the only block that drives the core.

## Interface
- `WIDTH`, default 4: operand and quotient width, and the number of core iterations.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req0_a` in WIDTH: dividend, requester 0.
- `req0_b` in WIDTH: divisor, requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same as port 0, for requester 1.
- `rsp_valid` out 1: response is available.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_q` out WIDTH: quotient.
- `rsp_dz` out 1: divisor was zero.
- `rsp_id` out 1: index of the requester being answered.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - Grant selection:
    - Only one valid: grant that port.
    - Both valid: grant the port equal to `rr_ptr`.
  - `reqN_ready` = (state==IDLE) && grant==N. It is combinational and never asserted for more than one port.
  - On handshake: latch `a`, `b` and `id`; set `rr_ptr` to the other port.
    - b==0: go to DONE with dz=1. The core is untouched.
    - b!=0: go to LOAD.
- **LOAD**
  - One cycle with `core_ld`=1; the core takes `a` and `b`.
  - Next state RUN, with iteration counter = WIDTH-1.
- **RUN**
  - `core_en`=1 every cycle; the counter decrements.
  - Leave for DONE after the cycle in which the counter is 0, i.e. exactly WIDTH RUN cycles.
- **DONE**
  - `rsp_valid`=1.
  - `rsp_q` = core quotient, or all-ones when dz=1. The core holds its value because `core_en`=0.
  - `rsp_id` and `rsp_dz` come from the latched values.
  - When `rsp_valid` && `rsp_ready`: go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Arithmetic: unsigned throughout; quotient = floor(a/b). The remainder is not exported.
- Requester rule: a requester holds valid, a and b stable until it sees ready. The block does not check this.

## Timing
- Reset values:
  - state IDLE, `rr_ptr` 0.
  - `rsp_valid`, `rsp_q`, `rsp_dz`, `rsp_id`, `busy` all 0.
  - `req0_ready` and `req1_ready` forced 0 while `rst_n`=0.
- Latency:
  - Request accepted at edge T: `rsp_valid` first high in cycle T+WIDTH+2 (T+6 for WIDTH=4).
  - Divisor zero: `rsp_valid` first high in cycle T+1.
- Throughput: at best one result per WIDTH+3 cycles (accept cycle, LOAD, WIDTH RUN cycles, DONE).
- Back-pressure: DONE may last any number of cycles. `rsp_q`, `rsp_dz` and `rsp_id` stay stable while `rsp_valid`=1.
- Reset asserted mid-operation, in any state: immediate return to IDLE and the reset values. The in-flight request is dropped and no response is issued. The core is also reset.
- Fairness: with both ports continuously valid, grants strictly alternate.

## Structure
- Package `div_pkg`:
  - state enum {IDLE, LOAD, RUN, DONE}
  - default `WIDTH`
  - `DZ_Q` all-ones constant
- Sub-module `div_core`:
  - Ports: `clk`, `rst_n`, `ld`, `en`, `a`, `b`, `q`.
  - `ld` loads a shifted divisor, clears the quotient and loads the zero-extended dividend.
  - Each `en` cycle performs one restore/shift step and shifts one quotient bit in.
  - It holds all state when `ld`=`en`=0.
- Counter: `$clog2(WIDTH)` bits. The response registers live in `div_sched`.

## Test plan
- Reset: with `rst_n`=0 and both valid=1 → both readies 0, all outputs 0. After release, port 0 is granted first.
- Single request, port 0, a=13, b=3 → `rsp_valid` 6 cycles after accept; q=4, dz=0, id=0. `core_ld` is high exactly 1 cycle and `core_en` exactly 4 cycles.
- Divide by zero, port 1, a=5, b=0 → `rsp_valid` the next cycle; q=4'hF, dz=1, id=1. `core_ld` is never asserted.
- Contention, both ports always valid, `rsp_ready`=1:
  - port 0 sends 15/1, port 1 sends 7/9.
  - Required grant order is 0,1,0,1, with responses 15/id0, 0/id1 repeating.
- Back-pressure: `rsp_ready`=0 for 3 cycles in DONE (a=9, b=2) → q=4 held stable, `busy`=1, no ready to either port. Exactly one response completes.
- Reset pulse in RUN (a=12, b=5) → outputs zero within the reset pulse and no response appears. The next request, a=12, b=5, returns q=2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider scheduler and its core.
package div_pkg;

    // Default operand/quotient width and number of core iterations.
    localparam int DEF_WIDTH = 4;

    // Quotient returned on divide-by-zero, sliced to the operand width by users.
    localparam logic [63:0] DZ_Q = '1;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_core.sv
// Restoring divider core: one quotient bit per enabled cycle, MSB first.
module div_core
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q
);

    // Partial remainder and divisor are wide enough to hold b shifted up by WIDTH-1.
    localparam int RW = 2 * WIDTH - 1;

    logic [RW-1:0]    r_rem;
    logic [RW-1:0]    r_div;
    logic [WIDTH-1:0] r_q;
    logic             w_ge;

    assign w_ge = (r_rem >= r_div);
    assign q    = r_q;

    // Load operands on ld; on en subtract when possible, walk the divisor down and shift in a quotient bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_div <= '0;
            r_q   <= '0;
        end else if (ld) begin
            r_rem <= {{(WIDTH-1){1'b0}}, a};
            r_div <= {b, {(WIDTH-1){1'b0}}};
            r_q   <= '0;
        end else if (en) begin
            if (w_ge) begin
                r_rem <= r_rem - r_div;
            end
            r_div <= r_div >> 1;
            r_q   <= {r_q[WIDTH-2:0], w_ge};
        end
    end

endmodule

// File: rtl/div_sched.sv
// Two-port round-robin arbiter and sequencer driving the shared divider core.
module div_sched
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic             rsp_dz,
    output logic             rsp_id,
    output logic             busy
);

    // Iteration counter counts WIDTH-1 down to 0, one step per RUN cycle.
    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_rr;
    logic             r_id;
    logic             r_dz;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;

    logic             w_any;
    logic             w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic             w_core_ld;
    logic             w_core_en;
    logic [WIDTH-1:0] w_core_q;

    // Grant the lone valid port, or the round-robin pointer when both are valid.
    assign w_any      = req0_valid | req1_valid;
    assign w_grant    = (req0_valid && req1_valid) ? r_rr : req1_valid;
    assign req0_ready = rst_n && (r_state == IDLE) && w_any && !w_grant;
    assign req1_ready = rst_n && (r_state == IDLE) && w_any && w_grant;
    assign w_accept   = req0_ready | req1_ready;
    assign w_sel_a    = w_grant ? req1_a : req0_a;
    assign w_sel_b    = w_grant ? req1_b : req0_b;

    // Response is presented only in DONE and is all zero otherwise.
    assign rsp_valid = (r_state == DONE);
    assign rsp_q     = rsp_valid ? (r_dz ? DZ_Q[WIDTH-1:0] : w_core_q) : '0;
    assign rsp_dz    = rsp_valid && r_dz;
    assign rsp_id    = rsp_valid && r_id;
    assign busy      = (r_state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and core control; a zero divisor skips the core entirely.
    always_comb begin
        w_next    = r_state;
        w_core_ld = 1'b0;
        w_core_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_sel_b == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                w_core_ld = 1'b1;
                w_next    = RUN;
            end
            RUN: begin
                w_core_en = 1'b1;
                if (r_cnt == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture the accepted request, move the pointer past the winner and run the iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr  <= 1'b0;
            r_id  <= 1'b0;
            r_dz  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_a  <= w_sel_a;
                r_b  <= w_sel_b;
                r_id <= w_grant;
                r_dz <= (w_sel_b == '0);
                r_rr <= ~w_grant;
            end
            if (r_state == LOAD) begin
                r_cnt <= CNT_LAST;
            end else if ((r_state == RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (w_core_ld),
        .en    (w_core_en),
        .a     (r_a),
        .b     (r_b),
        .q     (w_core_q)
    );

endmodule

// File: tb/tb_div_sched.sv
// Directed scoreboard bench for div_sched.
module tb_div_sched;
    import div_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_q;
    logic         rsp_dz;
    logic         rsp_id;
    logic         busy;

    typedef struct {
        logic [W-1:0] q;
        logic         dz;
        logic         id;
        int           accCycle;
        int           lat;
        bit           seen;
    } exp_t;

    exp_t sb[$];
    int   grantLog[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cycleNo   = 0;
    int   ldCount   = 0;
    int   enCount   = 0;
    int   respCount = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    div_sched #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_q      (rsp_q),
        .rsp_dz     (rsp_dz),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    // Reference result for one request: unsigned floor division, all-ones on zero divisor.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic id, input int cyc);
        exp_t e;
        e.q        = (b == '0) ? {W{1'b1}} : a / b;
        e.dz       = (b == '0);
        e.id       = id;
        e.accCycle = cyc;
        e.lat      = (b == '0) ? 1 : W + 2;
        e.seen     = 1'b0;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes mid-low-phase, score responses, then advance to the next falling edge.
    task automatic applyStimulus();
        exp_t e;
        #1;
        checkOutput("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
        if (req0_valid && req0_ready) begin
            sb.push_back(model(req0_a, req0_b, 1'b0, cycleNo));
            grantLog.push_back(0);
        end
        if (req1_valid && req1_ready) begin
            sb.push_back(model(req1_a, req1_b, 1'b1, cycleNo));
            grantLog.push_back(1);
        end
        if (dut.w_core_ld) ldCount++;
        if (dut.w_core_en) enCount++;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb[0];
                if (!e.seen) begin
                    checkOutput("latency", 32'(cycleNo - e.accCycle), 32'(e.lat));
                    e.seen = 1'b1;
                    sb[0]  = e;
                end
                checkOutput("rsp_q", 32'(rsp_q), 32'(e.q));
                checkOutput("rsp_dz", 32'(rsp_dz), 32'(e.dz));
                checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    respCount++;
                end
            end
        end
        @(posedge clk);
        cycleNo++;
        @(negedge clk);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int respBefore;

        rst_n      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b0;

        // Reset: both requesters valid, nothing may be granted or answered.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
        checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_q", 32'(rsp_q), 32'd0);
        checkOutput("rst_rsp_dz", 32'(rsp_dz), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("first_grant0", 32'(req0_ready), 32'd1);
        checkOutput("first_grant1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        $display("[TB] reset phase done");

        // Single request on port 0: 13/3.
        rsp_ready  = 1'b1;
        ldCount    = 0;
        enCount    = 0;
        req0_a     = 4'd13;
        req0_b     = 4'd3;
        req0_valid = 1'b1;
        applyStimulus();
        req0_valid = 1'b0;
        waitDrain(20);
        checkOutput("single_ld_cycles", 32'(ldCount), 32'd1);
        checkOutput("single_en_cycles", 32'(enCount), 32'(W));

        // Divide by zero on port 1: core must stay untouched.
        ldCount    = 0;
        enCount    = 0;
        req1_a     = 4'd5;
        req1_b     = 4'd0;
        req1_valid = 1'b1;
        applyStimulus();
        req1_valid = 1'b0;
        waitDrain(20);
        checkOutput("dz_ld_cycles", 32'(ldCount), 32'd0);
        checkOutput("dz_en_cycles", 32'(enCount), 32'd0);

        // Contention: both ports continuously valid, grants must alternate.
        grantLog.delete();
        respBefore = respCount;
        req0_a     = 4'd15;
        req0_b     = 4'd1;
        req1_a     = 4'd7;
        req1_b     = 4'd9;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        n = 0;
        while (grantLog.size() < 4 && n < 60) begin
            applyStimulus();
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitDrain(20);
        checkOutput("contention_grants", 32'(grantLog.size()), 32'd4);
        for (int i = 0; i < grantLog.size(); i++) begin
            checkOutput("grant_order", 32'(grantLog[i]), 32'(i % 2));
        end
        checkOutput("contention_rsps", 32'(respCount - respBefore), 32'd4);

        // Back-pressure: hold the response for three cycles with both requesters waiting.
        rsp_ready  = 1'b0;
        respBefore = respCount;
        req0_a     = 4'd9;
        req0_b     = 4'd2;
        req0_valid = 1'b1;
        applyStimulus();
        req0_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("bp_reach_done", 32'(rsp_valid), 32'd1);
        req0_a     = 4'd1;
        req0_b     = 4'd1;
        req1_a     = 4'd1;
        req1_b     = 4'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) begin
            #1;
            checkOutput("bp_ready0", 32'(req0_ready), 32'd0);
            checkOutput("bp_ready1", 32'(req1_ready), 32'd0);
            checkOutput("bp_busy", 32'(busy), 32'd1);
            applyStimulus();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        applyStimulus();
        #1;
        checkOutput("bp_rsp_count", 32'(respCount - respBefore), 32'd1);
        checkOutput("bp_released", 32'(rsp_valid), 32'd0);
        checkOutput("bp_idle", 32'(busy), 32'd0);

        // Reset pulse while the core is running: request dropped, then redone cleanly.
        respBefore = respCount;
        req0_a     = 4'd12;
        req0_b     = 4'd5;
        req0_valid = 1'b1;
        applyStimulus();
        req0_valid = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("run_busy", 32'(busy), 32'd1);
        rst_n      = 1'b0;
        req0_valid = 1'b1;
        #1;
        checkOutput("midrst_ready0", 32'(req0_ready), 32'd0);
        checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_rsp_q", 32'(rsp_q), 32'd0);
        checkOutput("midrst_rsp_dz", 32'(rsp_dz), 32'd0);
        checkOutput("midrst_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
        req0_valid = 1'b0;
        waitDrain(20);
        checkOutput("midrst_rsp_count", 32'(respCount - respBefore), 32'd1);
        repeat (3) applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
